// File: rtl/intr_entry_sequencer.sv
// ---------------------------------------------------------------------------
// intr_entry_sequencer
//
// Walks the CPU through interrupt entry once the port/interrupt block has
// latched a pending interrupt: freeze fetch and flush IF/ID, wait for the
// pipeline to drain, push the return PC on the stack, fetch the ISR vector,
// load the PC, then clear the pending flag and release HLT. Further entries
// are blocked until the CU executes RTI.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for intr_flag & ie & !in_isr; applies RTI
// DRAIN  | fetch frozen, minimum drain count then wait for pipe_idle
// SAVE   | writing return PC to M[sp_in], held until mem_ack
// VECTOR | reading ISR address from M[VEC_ADDR], held until mem_ack
// FINISH | one cycle: clear flag, release HLT, unfreeze fetch
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   intr_flag    latched pending interrupt
//   intr_clear   pulse: clear intr_flag
//   ie           global interrupt enable
//   rti_en       CU executing RTI
//   pipe_idle    nothing in flight past fetch
//   pc_in        return address
//   sp_in        current stack pointer
//   stall_fetch  freeze PC and fetch
//   flush        pulse: squash IF/ID on entry
//   mem_req      memory request, held until mem_ack
//   mem_we       1 = write, 0 = read
//   mem_addr     memory address
//   mem_wdata    write data (pc_in resized to DATA_W)
//   mem_ack      memory done, read data valid same cycle
//   mem_rdata    read data
//   sp_dec       pulse: decrement SP after the push
//   pc_load      pulse: load PC with pc_load_val
//   pc_load_val  ISR address
//   hlt_release  pulse: clear HLT in the CU
//   in_isr       high from vector load until RTI
//   busy         high whenever not IDLE
// ---------------------------------------------------------------------------
module intr_entry_sequencer #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int DRAIN_CYCLES = 4,
  parameter logic [ADDR_W-1:0] VEC_ADDR = ADDR_W'(8'h01)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              intr_flag,
  output logic              intr_clear,
  input  logic              ie,
  input  logic              rti_en,
  input  logic              pipe_idle,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [ADDR_W-1:0] sp_in,
  output logic              stall_fetch,
  output logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              sp_dec,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_load_val,
  output logic              hlt_release,
  output logic              in_isr,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRAIN  = 3'd1,
    S_SAVE   = 3'd2,
    S_VECTOR = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  // Drain counter starts at DRAIN_CYCLES-1 and is compared against zero in
  // its registered form, so DRAIN always lasts at least DRAIN_CYCLES cycles.
  localparam logic [3:0] CNT_INIT = 4'(DRAIN_CYCLES - 1);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              rti_pend, rti_pend_nxt;
  logic              in_isr_nxt;
  logic              flush_nxt, sp_dec_nxt, pc_load_nxt;
  logic              stall_nxt, mem_req_nxt, mem_we_nxt;
  logic              intr_clear_nxt, hlt_release_nxt, busy_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt, pc_load_val_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt;
  logic [DATA_W-1:0] wdata_ext;
  logic [ADDR_W-1:0] rdata_pc;

  // Sized casts zero-extend or truncate as needed.
  assign wdata_ext = DATA_W'(pc_in);
  assign rdata_pc  = ADDR_W'(mem_rdata);

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    rti_pend_nxt    = rti_pend;
    in_isr_nxt      = in_isr;
    mem_addr_nxt    = mem_addr;
    mem_wdata_nxt   = mem_wdata;
    pc_load_val_nxt = pc_load_val;
    flush_nxt       = 1'b0;
    sp_dec_nxt      = 1'b0;
    pc_load_nxt     = 1'b0;

    // RTI seen mid-sequence is held until we are back in IDLE.
    if (state != S_IDLE && rti_en) begin
      rti_pend_nxt = 1'b1;
    end

    case (state)
      S_IDLE: begin
        rti_pend_nxt = 1'b0;
        // in_isr is registered, so an RTI that coincides with a pending
        // interrupt ends service now and the new entry starts next cycle.
        if (rti_en || rti_pend) begin
          in_isr_nxt = 1'b0;
        end
        if (intr_flag && ie && !in_isr) begin
          state_nxt = S_DRAIN;
          flush_nxt = 1'b1;
          cnt_nxt   = CNT_INIT;
        end
      end
      S_DRAIN: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else if (pipe_idle) begin
          // Capture address/data once so the write stays stable even if
          // sp_in or pc_in move while the memory is stalling.
          state_nxt     = S_SAVE;
          mem_addr_nxt  = sp_in;
          mem_wdata_nxt = wdata_ext;
        end
      end
      S_SAVE: begin
        if (mem_ack) begin
          state_nxt     = S_VECTOR;
          sp_dec_nxt    = 1'b1;
          mem_addr_nxt  = VEC_ADDR;
          mem_wdata_nxt = '0;
        end
      end
      S_VECTOR: begin
        if (mem_ack) begin
          state_nxt       = S_FINISH;
          pc_load_nxt     = 1'b1;
          pc_load_val_nxt = rdata_pc;
          in_isr_nxt      = 1'b1;
          mem_addr_nxt    = '0;
        end
      end
      S_FINISH: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Level outputs follow the state being entered, so they change on the
    // same edge as the state register.
    stall_nxt       = (state_nxt == S_DRAIN) || (state_nxt == S_SAVE) ||
                      (state_nxt == S_VECTOR);
    mem_req_nxt     = (state_nxt == S_SAVE) || (state_nxt == S_VECTOR);
    mem_we_nxt      = (state_nxt == S_SAVE);
    intr_clear_nxt  = (state_nxt == S_FINISH);
    hlt_release_nxt = (state_nxt == S_FINISH);
    busy_nxt        = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      rti_pend    <= 1'b0;
      in_isr      <= 1'b0;
      stall_fetch <= 1'b0;
      flush       <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      sp_dec      <= 1'b0;
      pc_load     <= 1'b0;
      pc_load_val <= '0;
      intr_clear  <= 1'b0;
      hlt_release <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      rti_pend    <= rti_pend_nxt;
      in_isr      <= in_isr_nxt;
      stall_fetch <= stall_nxt;
      flush       <= flush_nxt;
      mem_req     <= mem_req_nxt;
      mem_we      <= mem_we_nxt;
      mem_addr    <= mem_addr_nxt;
      mem_wdata   <= mem_wdata_nxt;
      sp_dec      <= sp_dec_nxt;
      pc_load     <= pc_load_nxt;
      pc_load_val <= pc_load_val_nxt;
      intr_clear  <= intr_clear_nxt;
      hlt_release <= hlt_release_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_intr_entry_sequencer.sv
// ---------------------------------------------------------------------------
// tb_intr_entry_sequencer
//
// Drives interrupt entries against a small memory model with a programmable
// ack delay. Each entry pushes its expected stack write and vector value to
// a scoreboard; the monitor compares every write cycle and every pc_load
// against the head of the queue.
// ---------------------------------------------------------------------------
module tb_intr_entry_sequencer;

  localparam int DRAIN = 4;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] vec;
  } exp_t;

  logic       clk, rst;
  logic       intr_flag, intr_clear, ie, rti_en, pipe_idle;
  logic [7:0] pc_in, sp_in;
  logic       stall_fetch, flush, mem_req, mem_we, mem_ack;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       sp_dec, pc_load, hlt_release, in_isr, busy;
  logic [7:0] pc_load_val;

  logic [7:0] mem [256];
  exp_t       sb[$];
  int         n_vec, n_err;
  int         cyc, t0, flush_cyc, clr_cyc;
  int         n_sp_dec, n_wr_cyc, ack_cnt, ack_dly;
  int         s0, w0;
  logic       seen;

  intr_entry_sequencer #(
    .ADDR_W(8), .DATA_W(8), .DRAIN_CYCLES(DRAIN), .VEC_ADDR(8'h01)
  ) dut (
    .clk(clk), .rst(rst),
    .intr_flag(intr_flag), .intr_clear(intr_clear),
    .ie(ie), .rti_en(rti_en), .pipe_idle(pipe_idle),
    .pc_in(pc_in), .sp_in(sp_in),
    .stall_fetch(stall_fetch), .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .sp_dec(sp_dec), .pc_load(pc_load), .pc_load_val(pc_load_val),
    .hlt_release(hlt_release), .in_isr(in_isr), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] a, input logic [7:0] d, input logic [7:0] v);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.vec  = v;
    sb.push_back(e);
  endtask

  task automatic wait_clr(input int max);
    int n = 0;
    while (!intr_clear && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("clr_seen", intr_clear, 1'b1);
    clr_cyc = cyc;
  endtask

  task automatic wait_wr(input int max);
    int n = 0;
    while (!(mem_req && mem_we) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("wr_seen", mem_req && mem_we, 1'b1);
  endtask

  task automatic wait_rd(input int max);
    int n = 0;
    while (!(mem_req && !mem_we) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("rd_seen", mem_req && !mem_we, 1'b1);
  endtask

  task automatic rti_pulse();
    @(negedge clk);
    rti_en = 1'b1;
    @(negedge clk);
    rti_en = 1'b0;
    chk("rti_isr_clr", in_isr, 1'b0);
  endtask

  // Port-block model, memory model and scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      mem_ack = 1'b0;
      ack_cnt = 0;
    end else begin
      if (flush) flush_cyc = cyc;
      if (sp_dec) n_sp_dec++;
      if (intr_clear) intr_flag = 1'b0;
      if (pc_load) begin
        if (sb.size() == 0) begin
          chk("pc_load_unexp", 1'b1, 1'b0);
        end else begin
          e = sb.pop_front();
          chk("pc_load_val", pc_load_val, e.vec);
          chk("isr_on_load", in_isr, 1'b1);
        end
      end
      if (mem_req && mem_we) begin
        n_wr_cyc++;
        if (sb.size() == 0) begin
          chk("wr_unexp", 1'b1, 1'b0);
        end else begin
          e = sb[0];
          chk("wr_addr", mem_addr, e.addr);
          chk("wr_data", mem_wdata, e.data);
        end
      end
      if (mem_req && !mem_we) chk("rd_addr", mem_addr, 8'h01);
      if (mem_ack) begin
        mem_ack = 1'b0;
        ack_cnt = mem_req ? 1 : 0;
      end else if (mem_req) begin
        if (ack_cnt >= ack_dly) begin
          if (mem_we) mem[mem_addr] = mem_wdata;
          else        mem_rdata = mem[mem_addr];
          mem_ack = 1'b1;
          ack_cnt = 0;
        end else begin
          ack_cnt++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0; cyc = 0; n_sp_dec = 0; n_wr_cyc = 0;
    flush_cyc = 0; clr_cyc = 0; ack_cnt = 0; ack_dly = 1;
    rst = 1'b0; intr_flag = 1'b1; ie = 1'b1; rti_en = 1'b0; pipe_idle = 1'b1;
    pc_in = 8'h23; sp_in = 8'hFF; mem_ack = 1'b0; mem_rdata = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[1] = 8'h40;

    // 1: entry straight out of reset with the flag already pending
    repeat (3) @(negedge clk);
    chk("rst_ctl", {intr_clear, stall_fetch, flush, mem_req, mem_we, sp_dec,
                    pc_load, hlt_release, in_isr, busy}, 10'd0);
    chk("rst_bus", {mem_addr, mem_wdata, pc_load_val}, 24'd0);
    push_exp(8'hFF, 8'h23, 8'h40);
    t0 = cyc;
    rst = 1'b1;
    wait_clr(40);
    chk("flush_cyc", flush_cyc - t0, 1);
    chk("clr_gap", clr_cyc - flush_cyc, DRAIN + 4);
    chk("hlt_rel", hlt_release, 1'b1);
    chk("finish_stall", stall_fetch, 1'b0);
    chk("sp_dec_cnt", n_sp_dec, 1);
    chk("mem_ff", mem[8'hFF], 8'h23);
    @(negedge clk);
    chk("isr_set", in_isr, 1'b1);
    chk("idle_busy", busy, 1'b0);

    // 3: nesting blocked while in service; RTI re-opens entry a cycle later
    intr_flag = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | busy | stall_fetch;
    end
    chk("nest_blocked", seen, 1'b0);
    sp_in = 8'hFE; pc_in = 8'h31; mem[1] = 8'h55;
    push_exp(8'hFE, 8'h31, 8'h55);
    rti_pulse();
    chk("rti_no_flush", flush, 1'b0);
    @(negedge clk);
    chk("rti_reentry", flush, 1'b1);
    wait_clr(40);

    // 2: ie low holds off entry; ie high starts it on the next edge.
    //    The same entry exercises a 5-cycle-late write ack (4).
    @(negedge clk);
    rti_pulse();
    ie = 1'b0;
    intr_flag = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | busy;
    end
    chk("ie0_busy", seen, 1'b0);
    sp_in = 8'h80; pc_in = 8'h12; mem[1] = 8'h66;
    push_exp(8'h80, 8'h12, 8'h66);
    ack_dly = 5;
    s0 = n_sp_dec;
    w0 = n_wr_cyc;
    ie = 1'b1;
    @(negedge clk);
    chk("ie1_flush", flush, 1'b1);
    chk("ie1_busy", busy, 1'b1);
    wait_wr(20);
    sp_in = 8'h00;
    pc_in = 8'hAA;
    wait_clr(60);
    chk("wr_cycles", n_wr_cyc - w0, 6);
    chk("sp_dec_once", n_sp_dec - s0, 1);
    chk("mem_80", mem[8'h80], 8'h12);

    // 5: drain stretches while pipe_idle is low
    @(negedge clk);
    rti_pulse();
    ack_dly = 1;
    pipe_idle = 1'b0;
    sp_in = 8'h70; pc_in = 8'h09; mem[1] = 8'h77;
    push_exp(8'h70, 8'h09, 8'h77);
    intr_flag = 1'b1;
    @(negedge clk);
    chk("drain_flush", flush, 1'b1);
    repeat (DRAIN - 1) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("drain_hold", {mem_req, stall_fetch}, 2'b01);
    end
    pipe_idle = 1'b1;
    @(negedge clk);
    chk("save_go", mem_req && mem_we, 1'b1);
    wait_clr(40);

    // 6: reset in VECTOR drops everything; pending flag restarts entry
    @(negedge clk);
    rti_pulse();
    ack_dly = 3;
    sp_in = 8'h60; pc_in = 8'h44; mem[1] = 8'h88;
    push_exp(8'h60, 8'h44, 8'h88);
    intr_flag = 1'b1;
    wait_rd(40);
    #2;
    rst = 1'b0;
    mem_ack = 1'b0;
    #1;
    chk("arst_ctl", {intr_clear, stall_fetch, flush, mem_req, mem_we, sp_dec,
                     pc_load, hlt_release, in_isr, busy}, 10'd0);
    chk("arst_bus", {mem_addr, mem_wdata, pc_load_val}, 24'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    mem[1] = 8'h99;
    push_exp(8'h60, 8'h44, 8'h99);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_isr", in_isr, 1'b0);
    chk("post_rst_flush", flush, 1'b1);
    wait_clr(40);
    @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
